data_worker_arbiter: RTL and testbench

- Shares one data_worker (128-bit payload AHB master) between pNUM_REQ internal requesters.
- Round-robin grant; latches the winner's command and drives the worker's go/write/addr/wdata; routes worker done/rdata back to the winner only.
- Sits between the security/crypto clients and the single data_worker instance on the AHB master port.

---
 rtl/data_worker_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_data_worker_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_worker_arbiter.sv
// data_worker_arbiter: round-robin owner of one shared data_worker.
// Define DATA_WORKER_ARB_ADDR_CHECK_EN to reject out-of-window addresses.
module data_worker_arbiter #(
  parameter int pNUM_REQ = 4,
  parameter int pAHB_ADDR_WIDTH = 32,
  parameter int pPAYLOAD_SIZE_BITS = 128,
  parameter int pWATCHDOG_CYCLES = 64
`ifdef DATA_WORKER_ARB_ADDR_CHECK_EN
  ,
  parameter logic [pAHB_ADDR_WIDTH-1:0] pADDR_LO = '0,
  parameter logic [pAHB_ADDR_WIDTH-1:0] pADDR_HI =
    pAHB_ADDR_WIDTH'(32'hFFFF)
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic [pNUM_REQ-1:0] I_req_go,
  input  logic [pNUM_REQ-1:0] I_req_write,
  input  logic [pNUM_REQ*pAHB_ADDR_WIDTH-1:0] I_req_addr,
  input  logic [pNUM_REQ*pPAYLOAD_SIZE_BITS-1:0] I_req_wdata,
  output logic [pNUM_REQ-1:0] O_req_done,
  output logic O_req_err,
  output logic [pPAYLOAD_SIZE_BITS-1:0] O_req_rdata,
  output logic [pNUM_REQ-1:0] O_req_rdata_valid,
  output logic [pNUM_REQ-1:0] O_grant,
  output logic O_wkr_go,
  output logic O_wkr_write,
  output logic [pAHB_ADDR_WIDTH-1:0] O_wkr_addr,
  output logic [pPAYLOAD_SIZE_BITS-1:0] O_wkr_wdata,
  input  logic I_wkr_done,
  input  logic [pPAYLOAD_SIZE_BITS-1:0] I_wkr_rdata,
  input  logic I_wkr_rdata_valid,
  output logic O_wdt_err
);

  localparam int IW = $clog2(pNUM_REQ);
  localparam int CW = $clog2(pWATCHDOG_CYCLES + 1);
  localparam int AW = pAHB_ADDR_WIDTH;
  localparam int PW = pPAYLOAD_SIZE_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] g_idx;
  logic [CW-1:0] wdt_cnt;
  logic win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic win_ok;
  logic grant_fire;
  logic rej_fire;
  logic done_fire;
  int j;

  function automatic logic [pNUM_REQ-1:0] onehot(
    input logic [IW-1:0] i
  );
    logic [pNUM_REQ-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [IW-1:0] inc_ptr(
    input logic [IW-1:0] i
  );
    return (int'(i) == pNUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // first requesting slot at or after rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx = '0;
    cand = '0;
    j = 0;
    for (int k = 0; k < pNUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= pNUM_REQ) j = j - pNUM_REQ;
      cand = IW'(j);
      if (!win_found && I_req_go[cand]) begin
        win_found = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef DATA_WORKER_ARB_ADDR_CHECK_EN
  logic [AW-1:0] win_addr;
  logic err_q;
  assign win_addr = I_req_addr[win_idx*AW +: AW];
  assign win_ok = (win_addr >= pADDR_LO) && (win_addr <= pADDR_HI);
  assign O_req_err = err_q;
`else
  assign win_ok = 1'b1;
  assign O_req_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (win_found) state_nxt = win_ok ? BUSY : DONE;
      BUSY: if (I_wkr_done) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_fire = (state == IDLE) && win_found && win_ok;
    rej_fire = (state == IDLE) && win_found && !win_ok;
    done_fire = (state == BUSY) && I_wkr_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      g_idx <= '0;
      wdt_cnt <= '0;
      O_req_done <= '0;
      O_req_rdata <= '0;
      O_req_rdata_valid <= '0;
      O_grant <= '0;
      O_wkr_go <= 1'b0;
      O_wkr_write <= 1'b0;
      O_wkr_addr <= '0;
      O_wkr_wdata <= '0;
      O_wdt_err <= 1'b0;
`ifdef DATA_WORKER_ARB_ADDR_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      O_req_done <= '0;
      O_req_rdata_valid <= '0;
`ifdef DATA_WORKER_ARB_ADDR_CHECK_EN
      err_q <= 1'b0;
      if (rej_fire) begin
        O_req_done <= onehot(win_idx);
        err_q <= 1'b1;
        rr_ptr <= inc_ptr(win_idx);
      end
`endif
      if (grant_fire) begin
        g_idx <= win_idx;
        O_grant <= onehot(win_idx);
        O_wkr_go <= 1'b1;
        O_wkr_write <= I_req_write[win_idx];
        O_wkr_addr <= I_req_addr[win_idx*AW +: AW];
        O_wkr_wdata <= I_req_wdata[win_idx*PW +: PW];
        wdt_cnt <= '0;
      end
      if (done_fire) begin
        O_wkr_go <= 1'b0;
        O_grant <= '0;
        O_req_done <= onehot(g_idx);
        if (!O_wkr_write) begin
          O_req_rdata <= I_wkr_rdata;
          O_req_rdata_valid <= onehot(g_idx) &
            {pNUM_REQ{I_wkr_rdata_valid}};
        end
        rr_ptr <= inc_ptr(g_idx);
        wdt_cnt <= '0;
      end else if (state == BUSY) begin
        if (wdt_cnt != CW'(pWATCHDOG_CYCLES))
          wdt_cnt <= wdt_cnt + 1'b1;
        // flag is sticky; the transfer keeps waiting
        if (wdt_cnt == CW'(pWATCHDOG_CYCLES - 1))
          O_wdt_err <= 1'b1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = rej_fire;

endmodule

// File: tb/tb_data_worker_arbiter.sv
// tb_data_worker_arbiter: directed pins plus random traffic
// against a transaction-level reference model.
module tb_data_worker_arbiter;

  localparam int N = 4;
  localparam int AW = 32;
  localparam int PW = 128;
  localparam int WD = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_go = '0;
  logic [N-1:0] req_write = '0;
  logic [N-1:0][AW-1:0] req_addr = '0;
  logic [N-1:0][PW-1:0] req_wdata = '0;
  logic [N-1:0] O_req_done;
  logic O_req_err;
  logic [PW-1:0] O_req_rdata;
  logic [N-1:0] O_req_rdata_valid;
  logic [N-1:0] O_grant;
  logic O_wkr_go;
  logic O_wkr_write;
  logic [AW-1:0] O_wkr_addr;
  logic [PW-1:0] O_wkr_wdata;
  logic wkr_done = 1'b0;
  logic [PW-1:0] wkr_rdata = '0;
  logic wkr_rv = 1'b0;
  logic O_wdt_err;

  always #5 clk = ~clk;

  data_worker_arbiter #(
    .pNUM_REQ(N),
    .pAHB_ADDR_WIDTH(AW),
    .pPAYLOAD_SIZE_BITS(PW),
    .pWATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .I_req_go(req_go),
    .I_req_write(req_write),
    .I_req_addr(req_addr),
    .I_req_wdata(req_wdata),
    .O_req_done(O_req_done),
    .O_req_err(O_req_err),
    .O_req_rdata(O_req_rdata),
    .O_req_rdata_valid(O_req_rdata_valid),
    .O_grant(O_grant),
    .O_wkr_go(O_wkr_go),
    .O_wkr_write(O_wkr_write),
    .O_wkr_addr(O_wkr_addr),
    .O_wkr_wdata(O_wkr_wdata),
    .I_wkr_done(wkr_done),
    .I_wkr_rdata(wkr_rdata),
    .I_wkr_rdata_valid(wkr_rv),
    .O_wdt_err(O_wdt_err)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic cmp(string nm, logic [PW-1:0] a,
                     logic [PW-1:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // reference model: who owns the worker and what each requester sees
  bit m_valid = 0;
  int phase;
  int rr;
  int own;
  int busy_cycles;
  int mw;
  logic [N-1:0] e_grant, e_done, e_rdv;
  logic e_go, e_write, e_wdt;
  logic [AW-1:0] e_addr;
  logic [PW-1:0] e_wdata, e_rdata;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      phase = 0; rr = 0; own = 0; busy_cycles = 0;
      e_grant = '0; e_done = '0; e_rdv = '0;
      e_go = 0; e_write = 0; e_wdt = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
    end else if (m_valid) begin
      e_done = '0;
      e_rdv = '0;
      if (phase == 0) begin
        mw = -1;
        for (int k = 0; k < N; k++)
          if (mw < 0 && req_go[(rr + k) % N]) mw = (rr + k) % N;
        if (mw >= 0) begin
          own = mw;
          phase = 1;
          busy_cycles = 0;
          e_go = 1;
          e_grant = '0;
          e_grant[own] = 1'b1;
          e_write = req_write[own];
          e_addr = req_addr[own];
          e_wdata = req_wdata[own];
        end
      end else if (phase == 1) begin
        if (wkr_done) begin
          phase = 2;
          e_go = 0;
          e_grant = '0;
          e_done[own] = 1'b1;
          if (!e_write) begin
            e_rdata = wkr_rdata;
            e_rdv[own] = wkr_rv;
          end
          rr = (own + 1) % N;
        end else begin
          busy_cycles++;
          if (busy_cycles >= WD) e_wdt = 1;
        end
      end else begin
        phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("grant", PW'(O_grant), PW'(e_grant));
      cmp("wkr_go", PW'(O_wkr_go), PW'(e_go));
      cmp("req_done", PW'(O_req_done), PW'(e_done));
      cmp("rdata_valid", PW'(O_req_rdata_valid), PW'(e_rdv));
      cmp("req_rdata", O_req_rdata, e_rdata);
      cmp("req_err", PW'(O_req_err), '0);
      cmp("wdt_err", PW'(O_wdt_err), PW'(e_wdt));
      if (e_go) begin
        cmp("wkr_write", PW'(O_wkr_write), PW'(e_write));
        cmp("wkr_addr", PW'(O_wkr_addr), PW'(e_addr));
        cmp("wkr_wdata", O_wkr_wdata, e_wdata);
      end
    end
  end

  // worker stand-in and stepping
  bit wk_en = 0;
  bit spur_en = 0;
  bit wk_pend = 0;
  int wk_lat = 0;

  task automatic step();
    @(posedge clk);
    #2;
    if (wk_en) begin
      wkr_done = 1'b0;
      if (!wk_pend && O_wkr_go) begin
        wk_pend = 1;
        wk_lat = $urandom_range(0, 3);
      end
      if (wk_pend) begin
        if (wk_lat == 0) begin
          wkr_done = 1'b1;
          wkr_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
          wkr_rv = 1'($urandom_range(0, 1));
          wk_pend = 0;
        end else begin
          wk_lat--;
        end
      end else if (spur_en && !O_wkr_go && $urandom_range(0, 5) == 0) begin
        wkr_done = 1'b1;
        wkr_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
  endtask

  task automatic do_reset();
    wk_en = 0; wk_pend = 0; wkr_done = 0;
    req_go = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  logic [N-1:0] fair_exp [5];
  logic [N-1:0] grants [$];
  logic [N-1:0] prev_g;
  bit hit;

  initial begin
    fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1;
    step();
    cmp("reset_grant", PW'(O_grant), '0);
    cmp("reset_go", PW'(O_wkr_go), '0);
    cmp("reset_done", PW'(O_req_done), '0);
    cmp("reset_wdt", PW'(O_wdt_err), '0);
    rst = 1'b0;
    step();

    // single write by requester 1
    req_go[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1] = 32'h08;
    req_wdata[1] = 128'h31c3001967d4acf1bcb25768708627ae;
    step();
    cmp("wr_go", PW'(O_wkr_go), PW'(1));
    cmp("wr_grant", PW'(O_grant), PW'(4'b0010));
    cmp("wr_write", PW'(O_wkr_write), PW'(1));
    cmp("wr_addr", PW'(O_wkr_addr), PW'(32'h08));
    cmp("wr_wdata", O_wkr_wdata, 128'h31c3001967d4acf1bcb25768708627ae);
    wkr_done = 1'b1;
    step();
    cmp("wr_done", PW'(O_req_done), PW'(4'b0010));
    cmp("wr_rdv", PW'(O_req_rdata_valid), '0);
    wkr_done = 1'b0;
    req_go[1] = 1'b0;
    step();
    step();

    // single read by requester 0
    req_go[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0] = 32'h08;
    step();
    cmp("rd_go", PW'(O_wkr_go), PW'(1));
    wkr_done = 1'b1;
    wkr_rv = 1'b1;
    wkr_rdata = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    step();
    cmp("rd_done", PW'(O_req_done), PW'(4'b0001));
    cmp("rd_rdata", O_req_rdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    cmp("rd_rdv", PW'(O_req_rdata_valid), PW'(4'b0001));
    wkr_done = 1'b0;
    req_go[0] = 1'b0;
    step();
    step();

    // fairness with all requesters held high from reset
    do_reset();
    req_write = '0;
    req_go = '1;
    wk_en = 1;
    prev_g = '0;
    grants.delete();
    for (int i = 0; i < 200 && grants.size() < 5; i++) begin
      if (O_grant != '0 && prev_g == '0) grants.push_back(O_grant);
      prev_g = O_grant;
      step();
    end
    n_tests++;
    if (grants.size() != 5) begin
      n_fail++;
      $display("FAIL fair_timeout: got %0d grants required 5",
               grants.size());
    end else begin
      for (int i = 0; i < 5; i++)
        cmp($sformatf("fair_order%0d", i), PW'(grants[i]),
            PW'(fair_exp[i]));
    end

    // persistent requester must yield to the next one
    do_reset();
    req_go[2] = 1'b1;
    wk_en = 1;
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step();
      if (O_req_done[2]) hit = 1;
    end
    cmp("persist_done2", PW'(hit), PW'(1));
    req_go[3] = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      if (O_grant != '0) hit = 1;
    end
    cmp("persist_grant", PW'(O_grant), PW'(4'b1000));
    req_go = '0;
    for (int i = 0; i < 10; i++) step();

    // watchdog with a silent worker
    do_reset();
    req_go[0] = 1'b1;
    step();
    cmp("wdt_go", PW'(O_wkr_go), PW'(1));
    for (int i = 0; i < WD - 1; i++) step();
    cmp("wdt_at63", PW'(O_wdt_err), '0);
    step();
    cmp("wdt_at64", PW'(O_wdt_err), PW'(1));
    for (int i = 0; i < 5; i++) step();
    wkr_done = 1'b1;
    wkr_rv = 1'b0;
    step();
    cmp("wdt_late_done", PW'(O_req_done), PW'(4'b0001));
    cmp("wdt_sticky", PW'(O_wdt_err), PW'(1));
    wkr_done = 1'b0;
    req_go = '0;
    step();
    step();

    // reset in the middle of a transfer
    req_go[1] = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    cmp("rst_busy_go", PW'(O_wkr_go), '0);
    cmp("rst_busy_grant", PW'(O_grant), '0);
    cmp("rst_busy_wdt", PW'(O_wdt_err), '0);
    rst = 1'b0;
    req_go = '0;
    step();

    // random traffic
    wk_en = 1;
    spur_en = 1;
    for (int c = 0; c < 2500; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (req_go[i] && e_done[i]) begin
          if ($urandom_range(0, 3) != 0) req_go[i] = 1'b0;
        end else if (!req_go[i] && $urandom_range(0, 3) == 0) begin
          req_go[i] = 1'b1;
          req_write[i] = 1'($urandom_range(0, 1));
          req_addr[i] = 32'($urandom_range(0, 16'hFFFF));
          req_wdata[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end else if (req_go[i] && $urandom_range(0, 7) == 0) begin
          req_wdata[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
      end
    end
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
